onehot_decoder: RTL
===================

// Module: onehot_decoder
// PURPOSE
//  Binary-index to one-hot decoder. Inverse of the team's 16->4 encoder (decoder_in=4 -> 'h0010).
//  Registered output stage plus a 1-entry skid buffer, valid/ready on both sides.
//  Sits between index-producing control logic and one-hot select/enable consumers.
// PARAMETERS
//  DECODER_WIDTH  16  one-hot output width; index width IDX_W = $clog2(DECODER_WIDTH)
// PORTS
//  clk          in   1              clock, single domain
//  rst_n        in   1              asynchronous reset, active low
//  clk_en       in   1              clock enable; no state change when 0
//  in_valid     in   1              decoder_in valid
//  in_ready     out  1              block can accept decoder_in (registered)
//  decoder_in   in   IDX_W          binary index
//  out_valid    out  1              decoder_out/out_err valid
//  out_ready    in   1              downstream accepts
//  decoder_out  out  DECODER_WIDTH  one-hot word; all-zero when out_err=1
//  out_err      out  1              index was >= DECODER_WIDTH
//  err_cnt      out  8              saturating error count (only with DECODER_ERR_CNT_EN)
// BEHAVIOUR
//  Reset (async assert, sync release): decoder_out=0, out_err=0, out_valid=0, in_ready=0.
//   in_ready=1 on the first clk_en=1 edge after release. Reset mid-operation drops all entries.
//  Transfer = clk_en & valid & ready at a rising edge. With clk_en=0: nothing moves, all outputs
//   hold. The downstream shares clk_en.
//  Decode: decoder_out[i] = (decoder_in == i). If decoder_in >= DECODER_WIDTH (non-pow2 widths):
//   decoder_out=0, out_err=1.
//  Latency: an accepted input appears on the outputs at the next edge (1 cycle), when the
//   output register is free.
//  FSM (state_t):
//   EMPTY: out_valid=0.
//          in xfer -> ONE.
//   ONE:   out reg full.
//          in xfer & out xfer -> ONE, new word loaded.
//          in xfer only -> TWO, new word into skid.
//          out xfer only -> EMPTY.
//   TWO:   out reg and skid full; in_ready=0.
//          out xfer -> ONE, skid moves to out reg; in_ready=1 next edge.
//  in_ready is registered: in_ready = (next_state != TWO).
//  Order preserved. No drop or duplication under any valid/ready/clk_en pattern.
//  Outputs stay stable while out_valid=1 and out_ready=0.
// CONFIGURATION
//  DECODER_ERR_CNT_EN defined:
//   err_cnt port exists; reset value 0.
//   +1 per out xfer with out_err=1; saturates at 255.
//  DECODER_ERR_CNT_EN undefined:
//   err_cnt port and logic are absent.
//   out_err is still produced.
// STRUCTURE
//  decoder_pkg:
//   state_t enum {EMPTY, ONE, TWO}
//   DECODER_WIDTH_DEFAULT = 16
//   function onehot_decode(idx) returning {err, word}
//  onehot_decoder: FSM, out reg, skid reg.
//  Sub-module skid_buffer_1 (generic data-width 1-entry skid) is natural; the decode stays in
//   the package function.
// TESTING
//  1. Reset: hold rst_n=0, check all outputs 0.
//     Release: in_ready=1 after 1 edge, out_valid=0.
//  2. Single: decoder_in=4, out_ready=1
//     -> next cycle out_valid=1, decoder_out='h0010, out_err=0.
//  3. Stream: 8,15 back-to-back, out_ready=1
//     -> 'h0100 then 'h8000 on consecutive cycles, in_ready stays 1.
//  4. Backpressure: out_ready=0, offer 1,2,3
//     -> only 1,2 accepted, in_ready=0.
//     Release out_ready -> 'h0002, 'h0004, then 3 accepted -> 'h0008.
//  5. clk_en=0 for 3 cycles mid-stream with valids high
//     -> no transfers, outputs frozen; resumes intact.
//  6. DECODER_WIDTH=12, decoder_in=13
//     -> decoder_out=0, out_err=1.
//     With DECODER_ERR_CNT_EN: err_cnt 0->1; 300 errors -> 255.

Source files
------------

// File: rtl/decoder_pkg.sv
// rtl/decoder_pkg.sv - shared FSM states, width limits and the index-to-one-hot helper
package decoder_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    localparam int DECODER_WIDTH_DEFAULT = 16;

    // The helper decodes into a fixed-size word; callers slice out their own width.
    // Supported DECODER_WIDTH range is 2..128, so an index never exceeds IDX_MAX_W bits.
    localparam int DECODER_MAX_W = 256;
    localparam int IDX_MAX_W     = 8;

    // Returns {err, word}: word has a single bit set at position idx when idx < width,
    // otherwise word is all-zero and err is set.
    function automatic logic [DECODER_MAX_W:0] onehot_decode(
        input logic [IDX_MAX_W-1:0] idx,
        input int                   width
    );
        logic [DECODER_MAX_W-1:0] word;
        logic                     err;
        word = '0;
        for (int i = 0; i < DECODER_MAX_W; i++) begin
            word[i] = (idx == IDX_MAX_W'(i)) && (i < width);
        end
        err = (int'(idx) >= width);
        return {err, word};
    endfunction

endpackage

// File: rtl/skid_buffer_1.sv
// rtl/skid_buffer_1.sv - registered output stage with a one-entry skid, valid/ready on both sides
module skid_buffer_1
    import decoder_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clk_en,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data
);

    state_t            state_q, state_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic [DATA_W-1:0] skid_data_q, skid_data_d;
    logic              in_ready_q, in_ready_d;
    logic              in_xfer;
    logic              out_xfer;

    assign out_valid = (state_q != EMPTY);
    assign out_data  = out_data_q;
    assign in_ready  = in_ready_q;

    // Next-state and data movement; clk_en gates both handshakes so nothing moves while it is low.
    always_comb begin
        state_d     = state_q;
        out_data_d  = out_data_q;
        skid_data_d = skid_data_q;
        in_xfer     = clk_en && in_valid && in_ready_q;
        out_xfer    = clk_en && out_valid && out_ready;

        case (state_q)
            EMPTY: begin
                if (in_xfer) begin
                    state_d    = ONE;
                    out_data_d = in_data;
                end
            end
            ONE: begin
                if (in_xfer && out_xfer) begin
                    out_data_d = in_data;
                end else if (in_xfer) begin
                    state_d     = TWO;
                    skid_data_d = in_data;
                end else if (out_xfer) begin
                    state_d = EMPTY;
                end
            end
            TWO: begin
                // in_ready_q is low here, so only the output side can move.
                if (out_xfer) begin
                    state_d    = ONE;
                    out_data_d = skid_data_q;
                end
            end
            default: begin
                state_d = EMPTY;
            end
        endcase

        // Registered ready: it reflects the state being entered, and holds while clk_en is low
        // so the first enabled edge after reset is what raises it.
        in_ready_d = clk_en ? (state_d != TWO) : in_ready_q;
    end

    // State, data and ready registers; reset empties both entries and drops ready.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= EMPTY;
            out_data_q  <= '0;
            skid_data_q <= '0;
            in_ready_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            out_data_q  <= out_data_d;
            skid_data_q <= skid_data_d;
            in_ready_q  <= in_ready_d;
        end
    end

endmodule

// File: rtl/onehot_decoder.sv
// rtl/onehot_decoder.sv - binary index to one-hot decoder with skid-buffered output; DECODER_ERR_CNT_EN adds err_cnt
module onehot_decoder
    import decoder_pkg::*;
#(
    parameter  int DECODER_WIDTH = DECODER_WIDTH_DEFAULT,
    localparam int IDX_W         = $clog2(DECODER_WIDTH)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clk_en,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [IDX_W-1:0]         decoder_in,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DECODER_WIDTH-1:0] decoder_out,
    output logic                     out_err
`ifdef DECODER_ERR_CNT_EN
    ,
    output logic [7:0]               err_cnt
`endif
);

    logic [DECODER_MAX_W:0] dec_full;
    logic [DECODER_WIDTH:0] dec_entry;
    logic [DECODER_WIDTH:0] out_entry;

    // Decode ahead of the registers so each buffered entry already carries {err, word}.
    // Lanes above DECODER_WIDTH are zero by construction; merging them into err means an
    // index beyond the configured width can never leave as a valid-looking empty word.
    always_comb begin
        dec_full  = onehot_decode(IDX_MAX_W'(decoder_in), DECODER_WIDTH);
        dec_entry = {dec_full[DECODER_MAX_W] | (|dec_full[DECODER_MAX_W-1:DECODER_WIDTH]),
                     dec_full[DECODER_WIDTH-1:0]};
    end

    skid_buffer_1 #(
        .DATA_W (DECODER_WIDTH + 1)
    ) u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .clk_en    (clk_en),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (dec_entry),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_entry)
    );

    assign decoder_out = out_entry[DECODER_WIDTH-1:0];
    assign out_err     = out_entry[DECODER_WIDTH];

`ifdef DECODER_ERR_CNT_EN
    logic [7:0] err_cnt_q, err_cnt_d;

    // Count erroneous words as they leave, stopping at all-ones.
    always_comb begin
        err_cnt_d = err_cnt_q;
        if (clk_en && out_valid && out_ready && out_err && (err_cnt_q != 8'hFF)) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end
    end

    // Error counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt_q <= 8'd0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign err_cnt = err_cnt_q;
`endif

endmodule
